// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// magnitudes computed once per operation and signs fixed up at the end.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              prep_q;
  logic [1:0]        op_q;      // bit 1: divide, bit 0: unsigned
  logic [WIDTH-1:0]  rs_q;
  logic [WIDTH-1:0]  rt_q;
  logic [WIDTH-1:0]  mag_q;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]  upper_q;   // partial product high half / partial remainder
  logic [WIDTH-1:0]  lower_q;   // multiplier bits / dividend bits becoming quotient
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  lo_q;
  logic              busy_q;
  logic              done_q;

  logic              is_div;
  logic              neg_a;
  logic              neg_b;
  logic [WIDTH-1:0]  abs_rs;
  logic [WIDTH-1:0]  abs_rt;
  logic [WIDTH-1:0]  upper_d;
  logic [WIDTH-1:0]  lower_d;
  logic [WIDTH-1:0]  hi_d;
  logic [WIDTH-1:0]  lo_d;
  logic [WIDTH:0]    shifted;
  logic [WIDTH:0]    diff;
  logic [WIDTH:0]    sum;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]  quo;
  logic [WIDTH-1:0]  rem;

  assign is_div = op_q[1];
  assign neg_a  = ~op_q[0] & rs_q[WIDTH-1];
  assign neg_b  = ~op_q[0] & rt_q[WIDTH-1];
  assign abs_rs = neg_a ? -rs_q : rs_q;
  assign abs_rt = neg_b ? -rt_q : rt_q;

  // One iteration of either shift-add multiply or restoring divide.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    upper_d = upper_q;
    lower_d = lower_q;
    shifted = {upper_q, lower_q[WIDTH-1]};
    diff    = shifted - {1'b0, mag_q};
    sum     = {1'b0, upper_q} + (lower_q[0] ? {1'b0, mag_q} : '0);
    if (is_div) begin
      if (!diff[WIDTH]) begin
        upper_d = diff[WIDTH-1:0];
        lower_d = {lower_q[WIDTH-2:0], 1'b1};
      end else begin
        upper_d = shifted[WIDTH-1:0];
        lower_d = {lower_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      {upper_d, lower_d} = {sum, lower_q[WIDTH-1:1]};
    end
  end

  // Sign correction and divide-by-zero result, committed in FIX.
  always_comb begin
    product = {upper_q, lower_q};
    quo     = lower_q;
    rem     = upper_q;
    if (neg_a ^ neg_b) begin
      product = -product;
      quo     = -quo;
    end
    if (neg_a) rem = -rem;
    if (!is_div) begin
      hi_d = product[2*WIDTH-1:WIDTH];
      lo_d = product[WIDTH-1:0];
    end else if (rt_q == '0) begin
      hi_d = rs_q;
      lo_d = '1;
    end else begin
      hi_d = rem;
      lo_d = quo;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prep_q  <= 1'b0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      mag_q   <= '0;
      upper_q <= '0;
      lower_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                op_q    <= op[1:0];
                rs_q    <= rs_val;
                rt_q    <= rt_val;
                cnt_q   <= CW'(WIDTH - 1);
                prep_q  <= 1'b1;
                busy_q  <= 1'b1;
                state_q <= CALC;
              end
              OP_MTHI: hi_q <= rs_val;
              OP_MTLO: lo_q <= rs_val;
              default: ;
            endcase
          end
        end
        CALC: begin
          // First CALC cycle loads operand magnitudes; WIDTH iterations follow.
          if (prep_q) begin
            prep_q  <= 1'b0;
            upper_q <= '0;
            if (is_div) begin
              lower_q <= abs_rs;
              mag_q   <= abs_rt;
            end else begin
              lower_q <= abs_rt;
              mag_q   <= abs_rs;
            end
          end else begin
            upper_q <= upper_d;
            lower_q <= lower_d;
            if (cnt_q == '0) state_q <= FIX;
            else             cnt_q   <= cnt_q - 1'b1;
          end
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations checked against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  // Architectural HI/LO as the model sees them, and the result of the op in flight.
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [W-1:0] p_hi;
  logic [W-1:0] p_lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rh, output logic [31:0] rl);
    longint       sa;
    longint       sb;
    logic [63:0]  t;
    logic [63:0]  t2;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = '0;
    rl = '0;
    case (o)
      3'b000: begin t = sa * sb; rh = t[63:32]; rl = t[31:0]; end
      3'b001: begin t = {32'b0, a} * {32'b0, b}; rh = t[63:32]; rl = t[31:0]; end
      3'b010: begin
        if (b == 0) begin rl = '1; rh = a; end
        else begin t = sa / sb; t2 = sa % sb; rl = t[31:0]; rh = t2[31:0]; end
      end
      3'b011: begin
        if (b == 0) begin rl = '1; rh = a; end
        else begin rl = a / b; rh = a % b; end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick;
    case ($urandom_range(0, 5))
      0:       pick = 32'h0000_0000;
      1:       pick = 32'h0000_0001;
      2:       pick = 32'hFFFF_FFFF;
      3:       pick = 32'h8000_0000;
      default: pick = $urandom;
    endcase
  endfunction

  // Drive one iterative request and step through the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    model(o, a, b, p_hi, p_lo);
    tick;
    start = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
    op = 3'($urandom_range(0, 3));
    check("accept_busy", 64'(busy), 64'd1);
    check("accept_done", 64'(done), 64'd0);
    check("accept_hold", {hi, lo}, {m_hi, m_lo});
  endtask

  // Wait for done (bounded), checking latency, busy, HI/LO hold and the result.
  task automatic wait_done(input string tag, input bit poke);
    int lat = 41;
    bit hold_ok = 1'b1;
    bit busy_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      start = poke && (n == 5);
      op = 3'b101;
      rs_val = 32'hDEAD_BEEF;
      tick;
      if (done) begin lat = n; break; end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if ({hi, lo} !== {m_hi, m_lo}) hold_ok = 1'b0;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'd34);
    check({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
    check({tag, "_hold_during"}, 64'(hold_ok), 64'd1);
    check({tag, "_hi"}, 64'(hi), 64'(p_hi));
    check({tag, "_lo"}, 64'(lo), 64'(p_lo));
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    m_hi = p_hi;
    m_lo = p_lo;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    tick; tick;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // Start coinciding with reset is not accepted.
    start = 1'b1; op = 3'b000; rs_val = 32'd3; rt_val = 32'd4;
    tick;
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 64'(busy), 64'd0);
    tick;
    check("rst_start_idle", 64'(busy), 64'd0);

    issue(3'b000, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_neg", 1'b1);
    check("mult_neg_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_neg_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFEB);
    tick;
    check("done_pulse_width", 64'(done), 64'd0);

    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 1'b0);
    check("multu_max_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);

    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 1'b0);
    check("div_neg_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);

    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 1'b0);
    check("div_ovf_lo_const", 64'(lo), 64'h0000_0000_8000_0000);

    issue(3'b011, 32'd100, 32'd0);
    wait_done("divu_zero", 1'b0);

    issue(3'b010, 32'hFFFF_FF9C, 32'd0);
    wait_done("div_zero", 1'b0);

    // Back-to-back: second start driven during the done cycle.
    issue(3'b011, 32'd1000, 32'd7);
    wait_done("b2b_first", 1'b0);
    issue(3'b000, 32'h1234_5678, 32'hFEDC_BA98);
    wait_done("b2b_second", 1'b0);

    // MTHI / MTLO and a reserved code.
    op = 3'b100; rs_val = 32'hCAFE_0001; start = 1'b1;
    tick;
    start = 1'b0;
    m_hi = 32'hCAFE_0001;
    check("mthi_hi", 64'(hi), 64'(m_hi));
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    op = 3'b110; rs_val = 32'h5555_AAAA; start = 1'b1;
    tick;
    start = 1'b0;
    check("rsvd_busy", 64'(busy), 64'd0);
    check("rsvd_hold", {hi, lo}, {m_hi, m_lo});
    tick;
    check("rsvd_done", 64'(done), 64'd0);

    // Reset in mid-operation abandons the result.
    issue(3'b000, 32'd9, 32'd11);
    for (int k = 1; k <= 9; k++) begin
      start = (k == 5);
      op = 3'b001;
      tick;
    end
    start = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    begin
      bit quiet = 1'b1;
      for (int k = 0; k < 40; k++) begin
        tick;
        if (done !== 1'b0 || busy !== 1'b0 || {hi, lo} !== 64'd0) quiet = 1'b0;
      end
      check("abort_no_done", 64'(quiet), 64'd1);
    end
    op = 3'b101; rs_val = 32'd5; start = 1'b1;
    tick;
    start = 1'b0;
    m_lo = 32'd5;
    check("mtlo_lo", 64'(lo), 64'd5);
    check("mtlo_done", 64'(done), 64'd0);

    // Random operations against the model.
    for (int i = 0; i < 20; i++) begin
      issue(3'($urandom_range(0, 3)), pick(), pick());
      wait_done($sformatf("rnd%0d", i), i[0]);
    end

    tick;
    check("final_done_low", 64'(done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
